// File: rtl/normalize_round_pack_fp.sv
// normalize_round_pack_fp
//   Back end of the binary32 add/sub datapath. It takes the sign, the common
//   exponent and the 48-bit mantissa sum/difference. It normalizes the
//   mantissa over one or more cycles, rounds it under the RISC-V rounding
//   mode, resolves the special cases, and returns the packed result together
//   with the fflags bits.
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   in_valid / in_ready   upstream handshake (ready only while idle)
//   sign_in, exp_in       result sign, common biased exponent (0 = subnormal)
//   mant_in[47:0]         [47] carry, [46] hidden, [45:23] fraction,
//                         [22] guard, [21:0] sticky field
//   nan_in, inf1_in, inf2_in, sign1_in, sign2_in, res_zero_in
//                         operand classification from the front end
//   rm[2:0]               rounding mode (RNE/RTZ/RDN/RUP/RMM, others -> RNE)
//   out_valid / out_ready downstream handshake
//   result[31:0]          packed binary32 result
//   fflags[4:0]           {NV, DZ, OF, UF, NX}; DZ is always 0
module normalize_round_pack_fp #(
  parameter int SHIFT_PER_CYCLE = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        sign_in,
  input  logic [7:0]  exp_in,
  input  logic [47:0] mant_in,
  input  logic        nan_in,
  input  logic        inf1_in,
  input  logic        inf2_in,
  input  logic        sign1_in,
  input  logic        sign2_in,
  input  logic        res_zero_in,
  input  logic [2:0]  rm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [4:0]  fflags
);

  localparam logic [5:0] SPC    = 6'(SHIFT_PER_CYCLE);
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  typedef enum logic [1:0] {S_IDLE, S_NORM, S_ROUND, S_DONE} state_t;

  state_t      r_state, w_state_next;
  logic        r_sign;
  logic [9:0]  r_exp;      // the exponent never goes negative, so plain unsigned is enough
  logic [47:0] r_mant;
  logic        r_sticky;   // bits lost by the single right shift on carry-out
  logic [2:0]  r_rm;
  logic [31:0] r_result;
  logic [4:0]  r_fflags;

  logic        w_accept, w_is_nan, w_is_inf, w_is_zero;
  logic [5:0]  w_lzc, w_shamt;
  logic [9:0]  w_lim;
  logic        w_guard, w_lsb, w_stk, w_inc, w_nx, w_to_inf;
  logic [24:0] w_sig25;
  logic [23:0] w_sig;
  logic [9:0]  w_exp_r;
  logic [7:0]  w_expf;
  logic [31:0] w_rnd_result;
  logic [4:0]  w_rnd_flags;

  assign in_ready  = (r_state == S_IDLE) & ~reset;
  assign out_valid = (r_state == S_DONE);
  assign result    = r_result;
  assign fflags    = r_fflags;

  assign w_accept  = in_valid & in_ready;
  // Opposite-signed infinities make an invalid operation, just like a NaN operand.
  assign w_is_nan  = nan_in | (inf1_in & inf2_in & (sign1_in ^ sign2_in));
  assign w_is_inf  = inf1_in | inf2_in;
  assign w_is_zero = res_zero_in | (mant_in == 48'd0);

  // Leading-zero count of mant[46:0]. The highest set bit is the last one to assign.
  always_comb begin
    w_lzc = 6'd47;
    for (int i = 0; i < 47; i++) begin
      if (r_mant[i]) w_lzc = 6'(46 - i);
    end
  end

  // Per-cycle left shift: limited by the leading zeros, by the distance down to
  // exponent 1 (the subnormal floor), and by the per-cycle shifter width.
  always_comb begin
    w_lim   = r_exp - 10'd1;
    w_shamt = w_lzc;
    if ({4'b0000, w_shamt} > w_lim) w_shamt = w_lim[5:0];
    if (w_shamt > SPC) w_shamt = SPC;
  end

  // Rounding, overflow and packing from the normalized mantissa.
  always_comb begin
    w_guard = r_mant[22];
    w_lsb   = r_mant[23];
    w_stk   = (|r_mant[21:0]) | r_sticky;
    case (r_rm)
      RM_RTZ:  w_inc = 1'b0;
      RM_RDN:  w_inc = r_sign & (w_guard | w_stk);
      RM_RUP:  w_inc = ~r_sign & (w_guard | w_stk);
      RM_RMM:  w_inc = w_guard;
      default: w_inc = w_guard & (w_stk | w_lsb);
    endcase
    w_sig25 = {1'b0, r_mant[46:23]} + {24'd0, w_inc};
    if (w_sig25[24]) begin
      w_sig   = 24'h800000;
      w_exp_r = r_exp + 10'd1;
    end else begin
      w_sig   = w_sig25[23:0];
      w_exp_r = r_exp;
    end
    // A subnormal that rounds up into the hidden bit becomes the minimum normal,
    // because its exponent is already 1.
    w_expf = w_sig[23] ? w_exp_r[7:0] : 8'd0;
    w_nx   = w_guard | w_stk;
    case (r_rm)
      RM_RTZ:  w_to_inf = 1'b0;
      RM_RDN:  w_to_inf = r_sign;
      RM_RUP:  w_to_inf = ~r_sign;
      default: w_to_inf = 1'b1;
    endcase
    if (w_sig[23] && (w_exp_r >= 10'd255)) begin
      w_rnd_result = w_to_inf ? {r_sign, 31'h7F800000} : {r_sign, 31'h7F7FFFFF};
      w_rnd_flags  = 5'b00101;
    end else begin
      w_rnd_result = {r_sign, w_expf, w_sig[22:0]};
      w_rnd_flags  = {3'b000, w_nx & (w_expf == 8'd0), w_nx};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = (w_is_nan | w_is_inf | w_is_zero) ? S_DONE : S_NORM;
      S_NORM:  if (r_mant[47] || r_mant[46] || (r_exp <= 10'd1)) w_state_next = S_ROUND;
      S_ROUND: w_state_next = S_DONE;
      S_DONE:  if (out_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sign   <= 1'b0;
      r_exp    <= 10'd0;
      r_mant   <= 48'd0;
      r_sticky <= 1'b0;
      r_rm     <= 3'd0;
      r_result <= 32'd0;
      r_fflags <= 5'd0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_sign   <= sign_in;
          r_exp    <= (exp_in == 8'd0) ? 10'd1 : {2'b00, exp_in};
          r_mant   <= mant_in;
          r_sticky <= 1'b0;
          r_rm     <= rm;
          if (w_is_nan) begin
            r_result <= 32'h7FC00000;
            r_fflags <= 5'b10000;
          end else if (w_is_inf) begin
            r_result <= {inf1_in ? sign1_in : sign2_in, 31'h7F800000};
            r_fflags <= 5'b00000;
          end else if (w_is_zero) begin
            r_result <= {(rm == RM_RDN), 31'd0};
            r_fflags <= 5'b00000;
          end
        end
        S_NORM: begin
          if (r_mant[47]) begin
            r_mant   <= {1'b0, r_mant[47:1]};
            r_exp    <= r_exp + 10'd1;
            r_sticky <= r_sticky | r_mant[0];
          end else if (!r_mant[46] && (r_exp > 10'd1)) begin
            r_mant <= r_mant << w_shamt;
            r_exp  <= r_exp - {4'b0000, w_shamt};
          end
        end
        S_ROUND: begin
          r_result <= w_rnd_result;
          r_fflags <= w_rnd_flags;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_normalize_round_pack_fp.sv
module tb_normalize_round_pack_fp;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  fl;
    int          acc;
    int          lat;
  } item_t;

  typedef struct {
    bit        sign;
    bit [7:0]  e;
    bit [47:0] m;
    bit        nan, i1, i2, s1, s2, rz;
    bit [2:0]  rm;
  } op_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        sign_in;
  logic [7:0]  exp_in;
  logic [47:0] mant_in;
  logic        nan_in, inf1_in, inf2_in, sign1_in, sign2_in, res_zero_in;
  logic [2:0]  rm;
  int          cyc = 0;
  int          hold_until = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Reference: exact value mant * 2^(e-173), quantized to the binary32 ulp grid.
  function automatic void ref_model(input op_t op, output logic [31:0] res, output logic [4:0] fl);
    int e, msb, big_e, sh, expf;
    longint unsigned mant, q;
    bit g, s, inc, nx, to_inf;
    res = 32'd0;
    fl  = 5'd0;
    if (op.nan || (op.i1 && op.i2 && (op.s1 != op.s2))) begin
      res = 32'h7FC00000;
      fl  = 5'h10;
    end else if (op.i1 || op.i2) begin
      res = {op.i1 ? op.s1 : op.s2, 31'h7F800000};
    end else if (op.rz || op.m == 48'd0) begin
      res = (op.rm == 3'b010) ? 32'h80000000 : 32'h00000000;
    end else begin
      mant = 64'(op.m);
      e = (op.e == 8'd0) ? 1 : int'(op.e);
      msb = 0;
      for (int i = 0; i < 48; i++) if (mant[i]) msb = i;
      big_e = e + msb - 46;
      if (big_e < 1) big_e = 1;
      sh = big_e - e + 23;
      if (sh > 0) begin
        q = mant >> sh;
        g = ((mant >> (sh - 1)) & 64'd1) != 0;
        s = (mant & ((64'd1 << (sh - 1)) - 64'd1)) != 0;
      end else begin
        q = mant << (-sh);
        g = 1'b0;
        s = 1'b0;
      end
      case (op.rm)
        3'b001:  inc = 1'b0;
        3'b010:  inc = op.sign && (g || s);
        3'b011:  inc = !op.sign && (g || s);
        3'b100:  inc = g;
        default: inc = g && (s || q[0]);
      endcase
      q = q + 64'(inc);
      if (q == (64'd1 << 24)) begin
        q = 64'd1 << 23;
        big_e++;
      end
      nx = g || s;
      if (q >= (64'd1 << 23) && big_e >= 255) begin
        case (op.rm)
          3'b001:  to_inf = 1'b0;
          3'b010:  to_inf = op.sign;
          3'b011:  to_inf = !op.sign;
          default: to_inf = 1'b1;
        endcase
        res = to_inf ? {op.sign, 31'h7F800000} : {op.sign, 31'h7F7FFFFF};
        fl  = 5'b00101;
      end else begin
        expf = (q >= (64'd1 << 23)) ? big_e : 0;
        res = {op.sign, expf[7:0], q[22:0]};
        fl  = {3'b000, nx && (expf == 0), nx};
      end
    end
  endfunction

  // Cycles from the drive cycle to the first out_valid: one accept cycle, the
  // normalization cycles (shift chunks plus the final check), and one round cycle.
  function automatic int lat_of(input op_t op, input int spc);
    int e, msb, k;
    if (op.nan || op.i1 || op.i2 || op.rz || op.m == 48'd0) return 1;
    if (op.m[47]) return 3;
    e = (op.e == 8'd0) ? 1 : int'(op.e);
    msb = 0;
    for (int i = 0; i < 47; i++) if (op.m[i]) msb = i;
    k = 46 - msb;
    if (k > e - 1) k = e - 1;
    return 3 + (k + spc - 1) / spc;
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int SPC = (gi == 0) ? 8 : 1;
    logic        in_ready_w, out_valid_w;
    logic        out_ready_r = 1'b0;
    logic [31:0] result_w;
    logic [4:0]  fflags_w;
    item_t       sb_q[$];
    bit          seen = 1'b0;

    normalize_round_pack_fp #(.SHIFT_PER_CYCLE(SPC)) u_dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_w),
      .sign_in(sign_in), .exp_in(exp_in), .mant_in(mant_in), .nan_in(nan_in),
      .inf1_in(inf1_in), .inf2_in(inf2_in), .sign1_in(sign1_in), .sign2_in(sign2_in),
      .res_zero_in(res_zero_in), .rm(rm), .out_valid(out_valid_w), .out_ready(out_ready_r),
      .result(result_w), .fflags(fflags_w)
    );

    // Monitor: compares whatever the DUT presents against the head of its queue.
    always @(negedge clk) begin
      item_t it;
      out_ready_r = (cyc < hold_until) ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (!reset && out_valid_w) begin
        chk($sformatf("in_ready_low_while_valid[spc%0d]", SPC), 32'(in_ready_w), 32'd0);
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output[spc%0d]: got %08h expected no output", SPC, result_w);
        end else begin
          it = sb_q[0];
          if (!seen) begin
            chk($sformatf("latency[spc%0d]", SPC), 32'(cyc - it.acc), 32'(it.lat));
            seen = 1'b1;
          end
          chk($sformatf("result[spc%0d]", SPC), result_w, it.res);
          chk($sformatf("fflags[spc%0d]", SPC), 32'(fflags_w), 32'(it.fl));
          if (out_ready_r) begin
            $display("spc=%0d result=%08h fflags=%02h expect=%08h/%02h lat=%0d",
                     SPC, result_w, fflags_w, it.res, it.fl, it.lat);
            void'(sb_q.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  function automatic op_t mk(input bit s, input bit [7:0] e, input bit [47:0] m, input bit [2:0] r);
    op_t op;
    op = '{sign: s, e: e, m: m, nan: 1'b0, i1: 1'b0, i2: 1'b0, s1: 1'b0, s2: 1'b0, rz: 1'b0, rm: r};
    return op;
  endfunction

  task automatic issue(input op_t op, input bit push);
    int t;
    item_t it;
    logic [31:0] r;
    logic [4:0] f;
    t = 0;
    while (!(g_dut[0].in_ready_w && g_dut[1].in_ready_w) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) begin
      n_checks++;
      n_fail++;
      $display("FAIL in_ready_timeout: got 0 expected 1 within 2000 cycles");
    end
    sign_in = op.sign; exp_in = op.e; mant_in = op.m; nan_in = op.nan;
    inf1_in = op.i1; inf2_in = op.i2; sign1_in = op.s1; sign2_in = op.s2;
    res_zero_in = op.rz; rm = op.rm; in_valid = 1'b1;
    if (push) begin
      ref_model(op, r, f);
      it = '{res: r, fl: f, acc: cyc, lat: lat_of(op, 8)};
      g_dut[0].sb_q.push_back(it);
      it.lat = lat_of(op, 1);
      g_dut[1].sb_q.push_back(it);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((g_dut[0].sb_q.size() != 0 || g_dut[1].sb_q.size() != 0) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d/%0d pending expected 0/0",
               g_dut[0].sb_q.size(), g_dut[1].sb_q.size());
    end
  endtask

  initial begin
    op_t op;
    int sel, msb;
    longint unsigned rnd, low;
    reset = 1'b1; in_valid = 1'b0; sign_in = 1'b0; exp_in = 8'd0; mant_in = 48'd0;
    nan_in = 1'b0; inf1_in = 1'b0; inf2_in = 1'b0; sign1_in = 1'b0; sign2_in = 1'b0;
    res_zero_in = 1'b0; rm = 3'd0;
    repeat (3) @(negedge clk);
    chk("reset_in_ready", {30'd0, g_dut[1].in_ready_w, g_dut[0].in_ready_w}, 32'd0);
    chk("reset_out_valid", {30'd0, g_dut[1].out_valid_w, g_dut[0].out_valid_w}, 32'd0);
    chk("reset_result", g_dut[0].result_w | g_dut[1].result_w, 32'd0);
    chk("reset_fflags", 32'(g_dut[0].fflags_w | g_dut[1].fflags_w), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", {30'd0, g_dut[1].in_ready_w, g_dut[0].in_ready_w}, 32'd3);

    // Directed cases
    issue(mk(1'b0, 8'd127, 48'h8000_0000_0000, 3'd0), 1'b1);
    issue(mk(1'b0, 8'd127, 48'h2000_0000_0000, 3'd0), 1'b1);
    issue(mk(1'b0, 8'd127, 48'h0000_0080_0000, 3'd0), 1'b1);
    issue(mk(1'b0, 8'd127, 48'h4000_00C0_0000, 3'd0), 1'b1);
    issue(mk(1'b0, 8'd127, 48'h4000_00C0_0000, 3'd1), 1'b1);
    issue(mk(1'b1, 8'd127, 48'h4000_00C0_0000, 3'd2), 1'b1);
    issue(mk(1'b0, 8'd254, 48'h8000_0000_0000, 3'd0), 1'b1);
    issue(mk(1'b0, 8'd254, 48'h8000_0000_0000, 3'd1), 1'b1);
    issue(mk(1'b0, 8'd0,   48'h3FFF_FFC0_0000, 3'd0), 1'b1);
    op = mk(1'b0, 8'd10, 48'h1234_5678_9ABC, 3'd0); op.nan = 1'b1;
    issue(op, 1'b1);
    op = mk(1'b0, 8'd10, 48'h1234_5678_9ABC, 3'd0); op.i1 = 1'b1; op.i2 = 1'b1; op.s2 = 1'b1;
    issue(op, 1'b1);
    op = mk(1'b0, 8'd10, 48'h1234_5678_9ABC, 3'd2); op.rz = 1'b1;
    issue(op, 1'b1);
    drain();

    // Downstream stall: out_ready held low for several cycles while valid
    hold_until = cyc + 12;
    issue(mk(1'b1, 8'd100, 48'h4000_00C0_0001, 3'd3), 1'b1);
    drain();

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      op = mk($urandom_range(0, 1), 8'd0, 48'd0, 3'($urandom_range(0, 7)));
      sel = $urandom_range(0, 15);
      op.nan = (sel == 0);
      op.i1  = (sel == 1) || (sel == 3);
      op.i2  = (sel == 2) || (sel == 3);
      op.rz  = (sel == 4);
      op.s1  = $urandom_range(0, 1);
      op.s2  = $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0:       op.e = 8'($urandom_range(0, 30));
        1:       op.e = 8'($urandom_range(240, 254));
        default: op.e = 8'($urandom_range(1, 254));
      endcase
      msb = $urandom_range(0, 47);
      rnd = {$urandom, $urandom};
      low = (msb == 0) ? 64'd0 : (rnd & ((64'd1 << msb) - 64'd1));
      if ($urandom_range(0, 3) == 0) low = 64'd0;
      op.m = 48'((64'd1 << msb) | low);
      if (sel == 5) op.m = 48'd0;
      issue(op, 1'b1);
    end
    drain();

    // Reset while both instances are normalizing discards the operation
    issue(mk(1'b0, 8'd127, 48'h0000_0000_0001, 3'd0), 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midop_reset_out_valid", {30'd0, g_dut[1].out_valid_w, g_dut[0].out_valid_w}, 32'd0);
    chk("midop_reset_in_ready", {30'd0, g_dut[1].in_ready_w, g_dut[0].in_ready_w}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("after_reset_in_ready", {30'd0, g_dut[1].in_ready_w, g_dut[0].in_ready_w}, 32'd3);
    chk("after_reset_result", g_dut[0].result_w | g_dut[1].result_w, 32'd0);
    issue(mk(1'b1, 8'd3, 48'h0000_0000_0F00, 3'd4), 1'b1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
